// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit build still needs a one-bit counter.
  function automatic int calc_cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple-carry adder slice of W bits.
module digit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[W];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-bit slice, registered carry, valid/ready on both sides.
// Optional parallel self-check enabled by SERIAL_ADDER_SELF_CHECK_EN (fault tied 0 otherwise).
//
// state | meaning
// IDLE  | ready for operands, last result held on sum/carry_out
// CALC  | one digit added per clock, LSB first
// DONE  | result presented until out_ready
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             fault
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d;
  logic             c;
  logic [WIDTH-1:0] acc_next;

  digit_adder #(.W(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry_reg),
    .sum  (d),
    .cout (c)
  );

  // Partial sum lives apart from the sum port so the previous result stays visible during CALC.
  if (NDIG == 1) begin : g_single
    assign acc_next = d;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        acc <= '0;
      else if (state == CALC)
        acc <= acc_next[WIDTH-1:DIGIT];
    end

    assign acc_next = {d, acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= carry_in;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          a_sh      <= a_sh >> DIGIT;
          b_sh      <= b_sh >> DIGIT;
          carry_reg <= c;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= acc_next;
            carry_out <= c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_SELF_CHECK_EN
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic             cin_cap;
  logic [WIDTH-1:0] ref_sum;
  logic             ref_cout;
  logic             fault_r;

  digit_adder #(.W(WIDTH)) u_ref (
    .a    (a_cap),
    .b    (b_cap),
    .cin  (cin_cap),
    .sum  (ref_sum),
    .cout (ref_cout)
  );

  // Fault is sticky until reset; the serial result is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cap   <= '0;
      b_cap   <= '0;
      cin_cap <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_cap   <= a;
        b_cap   <= b;
        cin_cap <= carry_in;
      end
      if (state == CALC && cnt == LAST && {c, acc_next} != {ref_cout, ref_sum})
        fault_r <= 1'b1;
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder at 16/4, 8/2 and 16/16.
module tb_serial_digit_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [16:0] v;
    bit          chk;
    int          t;
  } exp_t;

  exp_t mq[$];
  exp_t eq[$];
  exp_t sq[$];

  // 16/4 instance
  logic m_iv = 0, m_ir, m_ci = 0, m_ov, m_or = 1, m_co, m_f;
  logic [15:0] m_a = '0, m_b = '0, m_sum;
  // 8/2 instance
  logic e_iv = 0, e_ir, e_ci = 0, e_ov, e_or = 1, e_co, e_f;
  logic [7:0] e_a = '0, e_b = '0, e_sum;
  // 16/16 instance
  logic s_iv = 0, s_ir, s_ci = 0, s_ov, s_or = 1, s_co, s_f;
  logic [15:0] s_a = '0, s_b = '0, s_sum;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
    .carry_in(m_ci), .out_valid(m_ov), .out_ready(m_or), .sum(m_sum),
    .carry_out(m_co), .fault(m_f));

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .a(e_a), .b(e_b),
    .carry_in(e_ci), .out_valid(e_ov), .out_ready(e_or), .sum(e_sum),
    .carry_out(e_co), .fault(e_f));

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
    .carry_in(s_ci), .out_valid(s_ov), .out_ready(s_or), .sum(s_sum),
    .carry_out(s_co), .fault(s_f));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic m_ov_q = 0, e_ov_q = 0, s_ov_q = 0;

  always @(negedge clk) begin : mon_m
    if (m_ov && !m_ov_q && mq.size() > 0) check("m_latency", cyc - mq[0].t, 4);
    if (m_ov && m_or) begin
      if (mq.size() == 0) begin
        tests++; fails++;
        $display("FAIL m_unexpected_output: got %0h, required none", {m_co, m_sum});
      end else begin
        exp_t x;
        x = mq.pop_front();
        if (x.chk) check("m_result", {m_co, m_sum}, x.v);
      end
    end
    m_ov_q = m_ov;
  end

  always @(negedge clk) begin : mon_e
    if (e_ov && !e_ov_q && eq.size() > 0) check("e_latency", cyc - eq[0].t, 4);
    if (e_ov && e_or) begin
      if (eq.size() == 0) begin
        tests++; fails++;
        $display("FAIL e_unexpected_output: got %0h, required none", {e_co, e_sum});
      end else begin
        exp_t x;
        x = eq.pop_front();
        if (x.chk) check("e_result", {e_co, e_sum}, x.v);
      end
    end
    e_ov_q = e_ov;
  end

  always @(negedge clk) begin : mon_s
    if (s_ov && !s_ov_q && sq.size() > 0) check("s_latency", cyc - sq[0].t, 1);
    if (s_ov && s_or) begin
      if (sq.size() == 0) begin
        tests++; fails++;
        $display("FAIL s_unexpected_output: got %0h, required none", {s_co, s_sum});
      end else begin
        exp_t x;
        x = sq.pop_front();
        if (x.chk) check("s_result", {s_co, s_sum}, x.v);
      end
    end
    s_ov_q = s_ov;
  end

  // ---------------- drivers ----------------
  task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [16:0] exp, input bit chk, input bit push);
    int n = 0;
    m_a = a; m_b = b; m_ci = ci; m_iv = 1'b1;
    while (!m_ir && n < 50) begin tick(); n++; end
    if (!m_ir) begin
      tests++; fails++;
      $display("FAIL m_accept_timeout: in_ready %0b, required 1", m_ir);
      m_iv = 1'b0;
      return;
    end
    tick();
    m_iv = 1'b0;
    if (push) mq.push_back('{v: exp, chk: chk, t: cyc});
  endtask

  task automatic send_e(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [8:0] exp);
    int n = 0;
    e_a = a; e_b = b; e_ci = ci; e_iv = 1'b1;
    while (!e_ir && n < 50) begin tick(); n++; end
    if (!e_ir) begin
      tests++; fails++;
      $display("FAIL e_accept_timeout: in_ready %0b, required 1", e_ir);
      e_iv = 1'b0;
      return;
    end
    tick();
    e_iv = 1'b0;
    eq.push_back('{v: {8'd0, exp}, chk: 1'b1, t: cyc});
  endtask

  task automatic send_s(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [16:0] exp);
    int n = 0;
    s_a = a; s_b = b; s_ci = ci; s_iv = 1'b1;
    while (!s_ir && n < 50) begin tick(); n++; end
    if (!s_ir) begin
      tests++; fails++;
      $display("FAIL s_accept_timeout: in_ready %0b, required 1", s_ir);
      s_iv = 1'b0;
      return;
    end
    tick();
    s_iv = 1'b0;
    sq.push_back('{v: exp, chk: 1'b1, t: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() + eq.size() + sq.size()) != 0 && n < 500) begin tick(); n++; end
    if ((mq.size() + eq.size() + sq.size()) != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0",
               mq.size() + eq.size() + sq.size());
    end
    tick();
    tick();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [8:0] ev;
    #12;
    check("rst_in_ready", m_ir, 1);
    check("rst_out_valid", m_ov, 0);
    check("rst_sum", m_sum, 0);
    check("rst_carry_out", m_co, 0);
    check("rst_fault", m_f, 0);
    check("rst_e_in_ready", e_ir, 1);
    check("rst_s_in_ready", s_ir, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // directed 16/4
    send_m(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1, 1);
    send_m(16'h0000, 16'h0000, 1'b1, 17'h00001, 1, 1);
    send_m(16'h8000, 16'h8000, 1'b0, 17'h10000, 1, 1);
    send_m(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1, 1);
    send_m(16'h0F0F, 16'hF0F0, 1'b1, 17'h10000, 1, 1);
    drain();

    // held result with out_ready low; extra in_valid must be ignored
    m_or = 1'b0;
    send_m(16'h1234, 16'h4321, 1'b1, 17'h05556, 1, 1);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", m_ov, 1);
      check("hold_sum", m_sum, 16'h5556);
      check("hold_in_ready", m_ir, 0);
      if (i >= 2 && i <= 5) begin
        m_iv = 1'b1; m_a = 16'hFFFF; m_b = 16'hFFFF;
      end else begin
        m_iv = 1'b0;
      end
      tick();
    end
    m_iv = 1'b0;
    m_or = 1'b1;
    tick();
    tick();
    repeat (6) tick();
    check("consumed_out_valid", m_ov, 0);
    check("consumed_in_ready", m_ir, 1);
    check("retained_sum", m_sum, 16'h5556);
    check("retained_carry", m_co, 0);
    drain();

    // reset during CALC
    send_m(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", m_ov, 0);
    check("midrst_sum", m_sum, 0);
    check("midrst_carry_out", m_co, 0);
    check("midrst_in_ready", m_ir, 1);
    tick();
    rst_n = 1'b1;
    tick();
    send_m(16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1, 1);
    send_m(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 1, 1);
    drain();

    // DIGIT == WIDTH
    send_s(16'h8000, 16'h8000, 1'b0, 17'h10000);
    send_s(16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    send_s(16'h1234, 16'h0001, 1'b0, 17'h01235);
    drain();

    // 8/2 directed corners then a sweep
    send_e(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    send_e(8'h80, 8'h80, 1'b0, 9'h100);
    send_e(8'h00, 8'h00, 1'b0, 9'h000);
    for (int a = 0; a < 256; a += 51) begin
      for (int b = 0; b < 256; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ev = 9'(a) + 9'(b) + 9'(ci);
          send_e(8'(a), 8'(b), ci[0], ev);
        end
      end
    end
    drain();

`ifdef SERIAL_ADDER_SELF_CHECK_EN
    check("fault_clean", m_f, 0);
    send_m(16'h0000, 16'h0000, 1'b0, 17'h00000, 0, 1);
    force dut_m.carry_reg = 1'b1;
    tick();
    release dut_m.carry_reg;
    drain();
    check("fault_set", m_f, 1);
    send_m(16'h0001, 16'h0001, 1'b0, 17'h00002, 1, 1);
    drain();
    check("fault_sticky", m_f, 1);
    rst_n = 1'b0;
    #1;
    check("fault_reset", m_f, 0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    check("fault_tied_m", m_f, 0);
    check("fault_tied_e", e_f, 0);
    check("fault_tied_s", s_f, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
